// File: rtl/genesis_clk_pkg.sv
// Shared constants for the Genesis clock-enable generator.
// Increments assume a 24-bit accumulator clocked at 100 MHz.
package genesis_clk_pkg;

    localparam int ACC_W_DEF = 24;

    typedef enum logic [1:0] {
        CH_M68K = 2'd0,
        CH_Z80  = 2'd1,
        CH_VDP  = 2'd2,
        CH_PSG  = 2'd3
    } ch_idx_e;

    // The PSG rate is the Z80 rate divided by 16.
    localparam logic [ACC_W_DEF-1:0] INC_M68K = 24'd1286813;  // 7.670 MHz
    localparam logic [ACC_W_DEF-1:0] INC_Z80  = 24'd600546;   // 3.580 MHz
    localparam logic [ACC_W_DEF-1:0] INC_VDP  = 24'd2252055;  // 13.423 MHz
    localparam logic [ACC_W_DEF-1:0] INC_PSG  = 24'd37534;    // 223.7 kHz

endpackage

// File: rtl/genesis_clk_enable_gen_channel.sv
// One NCO channel: phase accumulator, shadowed increment and toggle clock.
// A new increment takes effect only on a pulse boundary, or at once if the channel is idle.
module genesis_nco_channel
    import genesis_clk_pkg::*;
#(
    parameter int               ACC_W   = ACC_W_DEF,
    parameter logic [ACC_W-1:0] DEF_INC = {ACC_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             we_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             ce_o,
    output logic             clk_o,
    output logic             pend_o,
    output logic [ACC_W-1:0] inc_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] shadow_q, shadow_d;
    logic             ce_q, ce_d;
    logic             clk_q, clk_d;
    logic             pend_q, pend_d;
    logic [ACC_W:0]   sum_s;
    logic             carry_s;
    logic             immed_s;

    // Next-state: accumulate, toggle on carry, and decide when the shadow becomes active.
    always_comb begin
        sum_s    = {1'b0, acc_q} + {1'b0, inc_q};
        carry_s  = sum_s[ACC_W];
        // An idle channel has no pulse boundary to wait for.
        immed_s  = ~en_i | (inc_q == {ACC_W{1'b0}});
        acc_d    = acc_q;
        ce_d     = 1'b0;
        clk_d    = clk_q;
        inc_d    = inc_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        if (sync_i) begin
            acc_d  = {ACC_W{1'b0}};
            clk_d  = 1'b0;
            pend_d = 1'b0;
            if (we_i) begin
                inc_d    = inc_i;
                shadow_d = inc_i;
            end else begin
                inc_d    = shadow_q;
            end
        end else begin
            if (en_i) begin
                acc_d = sum_s[ACC_W-1:0];
                ce_d  = carry_s;
                if (carry_s) begin
                    clk_d = ~clk_q;
                end else begin
                    clk_d = clk_q;
                end
            end else begin
                ce_d = 1'b0;
            end
            if (we_i) begin
                shadow_d = inc_i;
                if (immed_s) begin
                    inc_d  = inc_i;
                    pend_d = 1'b0;
                end else begin
                    pend_d = 1'b1;
                end
            end else if (immed_s || carry_s) begin
                inc_d  = shadow_q;
                pend_d = 1'b0;
            end else begin
                pend_d = pend_q;
            end
        end
    end

    // State register with synchronous reset to the default increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= {ACC_W{1'b0}};
            inc_q    <= DEF_INC;
            shadow_q <= DEF_INC;
            ce_q     <= 1'b0;
            clk_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            inc_q    <= inc_d;
            shadow_q <= shadow_d;
            ce_q     <= ce_d;
            clk_q    <= clk_d;
            pend_q   <= pend_d;
        end
    end

    assign ce_o   = ce_q;
    assign clk_o  = clk_q;
    assign pend_o = pend_q;
    assign inc_o  = inc_q;

endmodule

// File: rtl/genesis_clk_enable_gen.sv
// Multi-channel fractional clock-enable generator for the Genesis top level.
// Decodes increment writes to one channel and broadcasts the phase-align strobe.
module genesis_clk_enable_gen
    import genesis_clk_pkg::*;
#(
    parameter int                      NUM_CH      = 4,
    parameter int                      ACC_W       = ACC_W_DEF,
    parameter logic [NUM_CH*ACC_W-1:0] DEFAULT_INC = {(NUM_CH*ACC_W){1'b0}},
    localparam int                     CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      CLK100MHZ,
    input  logic                      CPU_RESET,
    input  logic [NUM_CH-1:0]         en_i,
    input  logic                      sync_i,
    input  logic                      cfg_we_i,
    input  logic [CH_W-1:0]           cfg_ch_i,
    input  logic [ACC_W-1:0]          cfg_inc_i,
    output logic [NUM_CH-1:0]         ce_o,
    output logic [NUM_CH-1:0]         clk_o,
    output logic [NUM_CH-1:0]         pend_o,
    output logic [NUM_CH*ACC_W-1:0]   inc_o
);

    logic [NUM_CH-1:0] we_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        // Indices beyond NUM_CH match no channel, so such writes are dropped.
        assign we_s[g] = cfg_we_i & (cfg_ch_i == CH_W'(g));

        genesis_nco_channel #(
            .ACC_W   (ACC_W),
            .DEF_INC (DEFAULT_INC[g*ACC_W +: ACC_W])
        ) u_ch (
            .clk    (CLK100MHZ),
            .rst    (CPU_RESET),
            .en_i   (en_i[g]),
            .sync_i (sync_i),
            .we_i   (we_s[g]),
            .inc_i  (cfg_inc_i),
            .ce_o   (ce_o[g]),
            .clk_o  (clk_o[g]),
            .pend_o (pend_o[g]),
            .inc_o  (inc_o[g*ACC_W +: ACC_W])
        );
    end

endmodule

// File: tb/tb_genesis_clk_enable_gen.sv
// Self-checking bench: directed rate/phase scenarios plus random traffic against an arithmetic model.
module tb_genesis_clk_enable_gen;

    localparam int NCH = 3;
    localparam int AW  = 8;
    localparam int CW  = 2;
    localparam logic [NCH*AW-1:0] DEF = {8'd255, 8'd96, 8'd64};

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NCH-1:0]  en = '0;
    logic            sy = 1'b0;
    logic            we = 1'b0;
    logic [CW-1:0]   ch = '0;
    logic [AW-1:0]   cinc = '0;
    logic [NCH-1:0]  ce_o, clk_o, pend_o;
    logic [NCH*AW-1:0] inc_o;

    int errors = 0;
    int checks = 0;

    // behavioural model state (plain integers)
    int m_acc[NCH], m_inc[NCH], m_sh[NCH];
    bit m_ce[NCH], m_tog[NCH], m_pend[NCH];

    genesis_clk_enable_gen #(.NUM_CH(NCH), .ACC_W(AW), .DEFAULT_INC(DEF)) dut (
        .CLK100MHZ (clk),
        .CPU_RESET (rst),
        .en_i      (en),
        .sync_i    (sy),
        .cfg_we_i  (we),
        .cfg_ch_i  (ch),
        .cfg_inc_i (cinc),
        .ce_o      (ce_o),
        .clk_o     (clk_o),
        .pend_o    (pend_o),
        .inc_o     (inc_o)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        for (int c = 0; c < NCH; c++) begin
            bit wr;
            int total;
            bit wrap, idle;
            wr = we && (int'(ch) == c);
            if (rst) begin
                m_acc[c] = 0; m_ce[c] = 0; m_tog[c] = 0; m_pend[c] = 0;
                m_inc[c] = int'(DEF[c*AW +: AW]); m_sh[c] = m_inc[c];
            end else if (sy) begin
                m_acc[c] = 0; m_ce[c] = 0; m_tog[c] = 0; m_pend[c] = 0;
                if (wr) m_sh[c] = int'(cinc);
                m_inc[c] = m_sh[c];
            end else begin
                total = m_acc[c] + m_inc[c];
                wrap  = (total >= (1 << AW));
                idle  = !en[c] || (m_inc[c] == 0);
                m_ce[c] = en[c] && wrap;
                if (en[c]) begin
                    m_acc[c] = total % (1 << AW);
                    if (wrap) m_tog[c] = !m_tog[c];
                end
                if (wr) m_sh[c] = int'(cinc);
                if (idle) begin
                    m_inc[c] = m_sh[c]; m_pend[c] = 0;
                end else if (wrap && !wr) begin
                    m_inc[c] = m_sh[c]; m_pend[c] = 0;
                end else if (wr) begin
                    m_pend[c] = 1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [NCH-1:0] e, input logic s,
                        input logic w, input logic [CW-1:0] c, input logic [AW-1:0] v);
        logic [NCH-1:0] x_ce, x_clk, x_pend;
        logic [NCH*AW-1:0] x_inc;
        rst = r; en = e; sy = s; we = w; ch = c; cinc = v;
        @(posedge clk);
        model_edge();
        #1;
        for (int k = 0; k < NCH; k++) begin
            x_ce[k] = m_ce[k]; x_clk[k] = m_tog[k]; x_pend[k] = m_pend[k];
            x_inc[k*AW +: AW] = AW'(m_inc[k]);
        end
        checks++;
        assert (ce_o === x_ce) else begin errors++; $error("FAIL ce_o got=%b exp=%b t=%0t", ce_o, x_ce, $time); end
        checks++;
        assert (clk_o === x_clk) else begin errors++; $error("FAIL clk_o got=%b exp=%b t=%0t", clk_o, x_clk, $time); end
        checks++;
        assert (pend_o === x_pend) else begin errors++; $error("FAIL pend_o got=%b exp=%b t=%0t", pend_o, x_pend, $time); end
        checks++;
        assert (inc_o === x_inc) else begin errors++; $error("FAIL inc_o got=%h exp=%h t=%0t", inc_o, x_inc, $time); end
    endtask

    task automatic run(input logic [NCH-1:0] e, input int n);
        for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int cnt0, cnt1, cnt2, first0, first1, adj;
        logic prev1;

        // reset, then all channels free-running for 64 cycles
        step(1'b1, '0, 1'b0, 1'b0, '0, '0);
        step(1'b1, '0, 1'b0, 1'b0, '0, '0);
        cnt0 = 0; cnt1 = 0; cnt2 = 0; first0 = 0; adj = 0; prev1 = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            step(1'b0, 3'b111, 1'b0, 1'b0, '0, '0);
            cnt0 += int'(ce_o[0]); cnt1 += int'(ce_o[1]); cnt2 += int'(ce_o[2]);
            if (ce_o[0] && first0 == 0) first0 = k;
            if (ce_o[1] && prev1) adj++;
            prev1 = ce_o[1];
        end
        checks++; assert (first0 === 4) else begin errors++; $error("FAIL first_pulse0 got=%0d exp=4", first0); end
        checks++; assert (cnt0 === 16) else begin errors++; $error("FAIL count_inc64 got=%0d exp=16", cnt0); end
        checks++; assert (cnt1 === 24) else begin errors++; $error("FAIL count_inc96 got=%0d exp=24", cnt1); end
        checks++; assert (adj === 0) else begin errors++; $error("FAIL adjacent_inc96 got=%0d exp=0", adj); end
        checks++; assert (cnt2 === 63) else begin errors++; $error("FAIL count_inc255 got=%0d exp=63", cnt2); end

        // glitch-free reload on the edge-4 pulse
        step(1'b1, '0, 1'b0, 1'b0, '0, '0);
        step(1'b0, 3'b001, 1'b0, 1'b0, '0, '0);
        step(1'b0, 3'b001, 1'b0, 1'b1, 2'd0, 8'd128);
        run(3'b001, 10);

        // phase alignment by sync after free-running
        run(3'b011, 5);
        step(1'b0, 3'b011, 1'b1, 1'b0, '0, '0);
        first0 = 0; first1 = 0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b0, 3'b011, 1'b0, 1'b0, '0, '0);
            if (ce_o[0] && first0 == 0) first0 = k;
            if (ce_o[1] && first1 == 0) first1 = k;
        end
        // ch0 now runs inc=128 from the earlier reload
        checks++; assert (first0 === 2) else begin errors++; $error("FAIL sync_first0 got=%0d exp=2", first0); end
        checks++; assert (first1 === 3) else begin errors++; $error("FAIL sync_first1 got=%0d exp=3", first1); end

        // enable gap mid-phase (acc=128)
        step(1'b1, '0, 1'b0, 1'b0, '0, '0);
        run(3'b001, 2);
        run(3'b000, 10);
        run(3'b001, 4);

        // stop with inc=0, immediate restart, out-of-range write, reset mid-run
        step(1'b0, 3'b001, 1'b0, 1'b1, 2'd0, 8'd0);
        run(3'b001, 4);
        step(1'b0, 3'b001, 1'b0, 1'b1, 2'd0, 8'd64);
        run(3'b001, 3);
        step(1'b0, 3'b011, 1'b0, 1'b1, 2'd3, 8'd7);
        step(1'b0, 3'b011, 1'b0, 1'b1, 2'd1, 8'd200);
        step(1'b1, 3'b011, 1'b0, 1'b0, '0, '0);
        run(3'b011, 3);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [AW-1:0] v;
            case ($urandom_range(0, 3))
                0: v = 8'd0;
                1: v = 8'd255;
                default: v = AW'($urandom);
            endcase
            step(($urandom_range(0, 99) == 0), NCH'($urandom_range(0, 7) | ($urandom_range(0, 1) ? 7 : 0)),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 4) == 0), CW'($urandom_range(0, 3)), v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/genesis_clk_enable_gen.md
Name: genesis_clk_enable_gen

Overview:
Multi-channel fractional clock-enable generator that replaces fixed toggle-counter dividers in the Genesis top level. Each channel is a phase-accumulator NCO running off CLK100MHZ. Each produces a one-cycle clock-enable pulse and a toggled 50% square clock. The pulses give 68000, Z80, VDP and PSG timing at the correct average rates, so no ratio needs to be an integer divide of 100 MHz. Runtime rate reload is glitch-free (applied on a pulse boundary), and a global sync input phase-aligns all channels.

Parameters:
NUM_CH, 4, number of independent NCO channels
ACC_W, 24, accumulator and increment width in bits; pulse rate = f_clk * inc / 2^ACC_W
DEFAULT_INC, {NUM_CH{ACC_W'(0)}}, packed per-channel increment loaded at reset; channel 0 in LSBs

Ports:
CLK100MHZ  input  1  system clock, all logic on rising edge
CPU_RESET  input  1  synchronous active-high reset
en_i  input  NUM_CH  per-channel run enable
sync_i  input  1  global phase-align strobe, one cycle
cfg_we_i  input  1  increment write strobe
cfg_ch_i  input  $clog2(NUM_CH) (min 1)  channel selected for write
cfg_inc_i  input  ACC_W  new increment value
ce_o  output  NUM_CH  one-cycle clock-enable pulse per channel, registered
clk_o  output  NUM_CH  square clock per channel, toggles on each ce pulse, registered
pend_o  output  NUM_CH  shadow increment written but not yet applied
inc_o  output  NUM_CH*ACC_W  active increment per channel, for debug/readback

Behaviour:
- Reset (CPU_RESET=1 at an edge):
  - acc=0, ce_o=0, clk_o=0, pend_o=0.
  - inc_active = DEFAULT_INC slice; shadow = same.
- Priority per edge: reset > sync_i > cfg/normal run.
- Normal run, channel enabled:
  - sum = {1'b0,acc} + {1'b0,inc_active} (ACC_W+1 bits); acc <= sum[ACC_W-1:0].
  - ce_o <= sum[ACC_W]; if sum[ACC_W], clk_o <= ~clk_o.
- Latency: with acc=0 after reset and inc=2^(ACC_W-2), ce_o is high in the cycle after edges 4, 8, 12, ... counted from the first non-reset edge.
- inc=0: channel never pulses, acc stays 0.
- Max inc 2^ACC_W-1: pulses on 2^ACC_W-1 of every 2^ACC_W cycles.
- Disabled channel (en_i=0): acc and clk_o hold, ce_o <= 0. Re-enable resumes from the held phase with no extra pulse.
- cfg write: shadow[cfg_ch_i] <= cfg_inc_i and pend <= 1. If cfg_ch_i >= NUM_CH, the write is ignored.
- Apply rule: the shadow is copied into inc_active and pend is cleared at an edge where any of these holds:
  - (a) the channel's sum carries,
  - (b) en_i=0,
  - (c) inc_active==0.
- The accumulate at that edge always uses the old inc_active.
- A cfg write in the same cycle as an apply event lands in the shadow:
  - If pend was already 1, the older shadow value is discarded unapplied.
  - The new value stays pending (pend=1) until the next apply event.
  - Exception: for (b) or (c), the new value applies immediately at that edge.
- sync_i=1:
  - All channels: acc <= 0, ce_o <= 0, clk_o <= 0; all pending shadows are applied, pend cleared.
  - A cfg write in the same cycle is applied directly to inc_active.
  - Channels then count from identical phase.
- Reset mid-operation discards pending shadows and restores DEFAULT_INC.
- No combinational path from any input to any output.

Decomposition:
- Package genesis_clk_pkg:
  - ACC_W default.
  - Channel index enum: CH_M68K=0, CH_Z80=1, CH_VDP=2, CH_PSG=3.
  - Increment constants for 24-bit accumulator at 100 MHz: INC_M68K=1286813 (7.670 MHz), INC_Z80=600546 (3.580 MHz), INC_VDP and INC_PSG as derived.
- Sub-module genesis_nco_channel: one accumulator, shadow/pend logic and toggle flop.
- The top instantiates NUM_CH channels via generate and decodes cfg_ch_i / broadcasts sync_i.

Test Plan:
1. ACC_W=8, inc0=64, en=1 from reset -> ce_o[0] high after edges 4, 8, 12, ...; clk_o[0] toggles at each, period 8 cycles.
2. ACC_W=8, inc1=96 for 64 cycles -> exactly 24 ce pulses, spacing pattern 3,3,2 repeating, never two adjacent pulses.
3. Running inc0=64, write inc0=128 at cycle 2 -> pend_o[0]=1 until edge 4 pulse; inc_o shows 128 after it; next pulses every 2 cycles; no short or double pulse at the switch.
4. Channels with inc 64 and 96 free-running, sync_i pulsed -> all acc=0, clk_o=0; next pulses at edges 4 and 3 after sync respectively, in phase with a fresh reset.
5. en_i[0] dropped for 10 cycles mid-phase (acc=128) -> no ce_o[0] during gap; first pulse 2 cycles after re-enable.
6. cfg write with inc=0 -> channel stops pulsing; a subsequent write of 64 applies immediately (pend_o cleared next edge); CPU_RESET mid-run restores DEFAULT_INC, clears pend_o, ce_o and clk_o.
